l1_cache_tag_assoc: RTL and testbench
=====================================

// Module: l1_cache_tag_assoc
//
// PURPOSE
//  Parametrised set-associative L1 tag array: NUM_WAYS ways x NUM_SETS sets.
//  Stores valid bit + tag per line. Lookup issues in cycle N; hit/way results
//  appear in cycle N+1.
//  Adds over the fixed 4-way tag block:
//   - self-clearing of valid bits after reset
//   - write-to-read forwarding
//   - one-hot and encoded hit outputs, plus a multi-hit error flag
//   - optional pseudo-LRU victim tracking
//  Sits between the L1 request pipeline and the L1 data array / fill logic.
//
// PARAMETERS
//  NUM_WAYS       4    ways; power of 2, 2..8
//  NUM_SETS       32   sets; power of 2, 2..256
//  OFFSET_WIDTH   6    line-offset bits (64-byte lines)
//  (localparam) WAY_W = $clog2(NUM_WAYS)
//  (localparam) SET_W = $clog2(NUM_SETS)
//  (localparam) TAG_W = 32 - OFFSET_WIDTH - SET_W
//
// PORTS
//  clk           in   1         clock
//  reset         in   1         reset (see BEHAVIOUR)
//  address_i     in   32        lookup address; set = [OFFSET_WIDTH+SET_W-1:OFFSET_WIDTH], tag = [31:OFFSET_WIDTH+SET_W]
//  access_i      in   1         lookup request, cycle N
//  ready_o       out  1         1 = init sweep done, lookups/updates accepted
//  cache_hit_o   out  1         cycle N+1: some valid way matched and access was accepted
//  hit_oh_o      out  NUM_WAYS  cycle N+1: one-hot per-way match (gated by accepted access)
//  hit_way_o     out  WAY_W     cycle N+1: encoded hit way; lowest index on multi-hit
//  multi_hit_o   out  1         cycle N+1: >1 way matched (error)
//  update_i      in   1         fill: write tag, valid=1
//  invalidate_i  in   1         write valid=0
//  update_way_i  in   WAY_W     way to write
//  update_set_i  in   SET_W     set to write
//  update_tag_i  in   TAG_W     tag to write
//  lru_way_o     out  WAY_W     cycle N+1: PLRU victim for the looked-up set
//
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset assert: all flops clear; every output reads 0. FSM enters CLEAR with set counter = 0.
//  - CLEAR: each cycle writes valid=0, tag=0 to all ways of set[counter], then counter++.
//    - Leaves CLEAR after set NUM_SETS-1 is written, i.e. NUM_SETS cycles after reset release.
//    - Then enters READY; ready_o=1 in the same cycle the state changes.
//  - During CLEAR: access_i, update_i and invalidate_i are ignored (no write, cache_hit_o=0).
//  - Reset asserted mid-CLEAR or in READY: the sweep restarts from set 0.
//  - Tags and valid bits live in sram_1r1w, one instance per way; all ways are read in parallel.
//  - Lookup latency is 1 cycle. The set, tag and access are latched in cycle N.
//  - Cycle N+1 compare: hit[w] = valid[w] && tag[w] == latched_tag.
//  - Cycle N+1 gating: when the latched access is 0, cache_hit_o, hit_oh_o, hit_way_o and multi_hit_o are all 0.
//  - Write-to-read forward: an update or invalidate in cycle N to the set looked up in cycle N is visible in the cycle-N+1 result.
//    - The forwarded way uses the written valid and tag; all other ways use the SRAM data.
//  - update_i and invalidate_i together: update wins (valid=1, tag written).
//  - Writes take 1 cycle; back-to-back writes to any set/way are allowed every cycle.
//  - Multi-hit: multi_hit_o=1, cache_hit_o=1, hit_way_o = lowest matching index.
//
// CONFIGURATION
//  L1_TAG_PLRU_EN defined:
//   - Tree-PLRU, NUM_WAYS-1 bits per set, held in flops; async reset to 0.
//   - CLEAR also zeroes each set's bits as the sweep passes it.
//   - Cycle-N+1 hit: the latched set's bits are pointed away from hit_way_o.
//   - update_i: the update set's bits are pointed away from update_way_i.
//   - Hit touch and fill in the same cycle to the same set: the hit touch is applied first, then the fill.
//   - lru_way_o reflects the latched set's bits before this cycle's touch.
//  L1_TAG_PLRU_EN undefined:
//   - No PLRU state; lru_way_o tied to 0.
//
// TESTING
//  1. Reset low then high -> ready_o=0 for exactly NUM_SETS cycles then 1; lookup of any address -> cache_hit_o=0.
//  2. Fill way 2, set 5, tag 0x1234; lookup at {0x1234,5,0x00} -> next cycle cache_hit_o=1, hit_way_o=2, hit_oh_o=4'b0100.
//  3. Same cycle: invalidate way 2 set 5 and look up set 5 -> next cycle cache_hit_o=0 (forwarding); tag 0x1235 -> miss.
//  4. Force the same tag into ways 1 and 3 of set 7; look up -> multi_hit_o=1, hit_way_o=1.
//  5. Reset mid-CLEAR (counter=10) -> sweep restarts: ready_o stays 0 for NUM_SETS cycles after reset release.
//  6. PLRU (4 ways): fill ways 0,1,2,3 in set 0 -> lru_way_o=0; hit way 0 -> next lookup lru_way_o=2.

Source files
------------

// File: rtl/l1_cache_tag_assoc.sv
// Set-associative L1 tag array with post-reset clear sweep, write-to-read forwarding,
// one-hot/encoded/multi-hit outputs. Optional tree-PLRU victim tracking under `L1_TAG_PLRU_EN.

module sram_1r1w #(
  parameter int DW    = 8,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-during-write returns the old word; the parent forwards the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end
endmodule

module l1_cache_tag_assoc #(
  parameter int NUM_WAYS     = 4,
  parameter int NUM_SETS     = 32,
  parameter int OFFSET_WIDTH = 6,
  localparam int WAY_W       = $clog2(NUM_WAYS),
  localparam int SET_W       = $clog2(NUM_SETS),
  localparam int TAG_W       = 32 - OFFSET_WIDTH - SET_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         address_i,
  input  logic                access_i,
  output logic                ready_o,
  output logic                cache_hit_o,
  output logic [NUM_WAYS-1:0] hit_oh_o,
  output logic [WAY_W-1:0]    hit_way_o,
  output logic                multi_hit_o,
  input  logic                update_i,
  input  logic                invalidate_i,
  input  logic [WAY_W-1:0]    update_way_i,
  input  logic [SET_W-1:0]    update_set_i,
  input  logic [TAG_W-1:0]    update_tag_i,
  output logic [WAY_W-1:0]    lru_way_o
);
  typedef enum logic {CLEAR, READY} state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SET_W'(NUM_SETS - 1)) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  assign ready_o = (state_q == READY);

  logic [SET_W-1:0] set_in;
  logic [TAG_W-1:0] tag_in;
  logic             wr_req;
  logic [SET_W-1:0] waddr;
  logic [TAG_W:0]   wdata;

  assign set_in = address_i[OFFSET_WIDTH+SET_W-1:OFFSET_WIDTH];
  assign tag_in = address_i[31:OFFSET_WIDTH+SET_W];
  assign wr_req = ready_o && (update_i || invalidate_i);
  // During the sweep every way of set[cnt] is written with {valid=0, tag=0}.
  assign waddr  = ready_o ? update_set_i : cnt_q;
  assign wdata  = ready_o ? {update_i, update_tag_i} : '0;

  logic [TAG_W:0] rd [NUM_WAYS];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic we;
    assign we = !ready_o || (wr_req && update_way_i == WAY_W'(w));
    sram_1r1w #(.DW(TAG_W + 1), .DEPTH(NUM_SETS)) u_sram (
      .clk   (clk),
      .rst_n (reset),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (set_in),
      .rdata (rd[w])
    );
  end

  logic             acc_q;
  logic [SET_W-1:0] set_q;
  logic [TAG_W-1:0] tag_q;
  logic             fwd_q;
  logic [WAY_W-1:0] fwd_way_q;
  logic             fwd_valid_q;
  logic [TAG_W-1:0] fwd_tag_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= 1'b0;
      set_q       <= '0;
      tag_q       <= '0;
      fwd_q       <= 1'b0;
      fwd_way_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_tag_q   <= '0;
    end else begin
      acc_q       <= access_i && ready_o;
      set_q       <= set_in;
      tag_q       <= tag_in;
      fwd_q       <= wr_req && (update_set_i == set_in);
      fwd_way_q   <= update_way_i;
      fwd_valid_q <= update_i;
      fwd_tag_q   <= update_tag_i;
    end
  end

  logic [NUM_WAYS-1:0] hit_raw;

  always_comb begin
    hit_raw = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (fwd_q && fwd_way_q == WAY_W'(w))
        hit_raw[w] = fwd_valid_q && (fwd_tag_q == tag_q);
      else
        hit_raw[w] = rd[w][TAG_W] && (rd[w][TAG_W-1:0] == tag_q);
    end
  end

  assign hit_oh_o    = acc_q ? hit_raw : '0;
  assign cache_hit_o = |hit_oh_o;
  assign multi_hit_o = |(hit_oh_o & (hit_oh_o - 1'b1));

  always_comb begin
    hit_way_o = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_oh_o[w]) hit_way_o = WAY_W'(w);
    end
  end

`ifdef L1_TAG_PLRU_EN
  localparam int PW = NUM_WAYS - 1;

  logic [PW-1:0] plru_q [NUM_SETS];
  logic [PW-1:0] hit_touch, fill_base, fill_touch;

  // Heap-ordered tree: node n has children 2n+1 (0 = left) and 2n+2 (1 = right).
  // A node bit points at the subtree holding the victim.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] b, input logic [WAY_W-1:0] way);
    logic [PW-1:0]    r;
    logic [WAY_W-1:0] n, w;
    logic             d;
    r = b;
    n = '0;
    w = way;
    for (int l = 0; l < WAY_W; l++) begin
      d    = w[WAY_W-1];
      r[n] = ~d;
      n    = (n << 1) + WAY_W'(1) + WAY_W'(d);
      w    = w << 1;
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [PW-1:0] b);
    logic [WAY_W-1:0] n, v;
    logic             d;
    n = '0;
    v = '0;
    for (int l = 0; l < WAY_W; l++) begin
      d = b[n];
      v = (v << 1) | WAY_W'(d);
      n = (n << 1) + WAY_W'(1) + WAY_W'(d);
    end
    return v;
  endfunction

  // A same-cycle fill to the hit set builds on the already-touched bits.
  assign hit_touch  = plru_touch(plru_q[set_q], hit_way_o);
  assign fill_base  = (cache_hit_o && update_set_i == set_q) ? hit_touch : plru_q[update_set_i];
  assign fill_touch = plru_touch(fill_base, update_way_i);
  assign lru_way_o  = plru_victim(plru_q[set_q]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else if (!ready_o) begin
      plru_q[cnt_q] <= '0;
    end else begin
      if (cache_hit_o) plru_q[set_q] <= hit_touch;
      if (update_i)    plru_q[update_set_i] <= fill_touch;
    end
  end
`else
  assign lru_way_o = '0;
`endif

endmodule

// File: tb/tb_l1_cache_tag_assoc.sv
// Scoreboard bench for l1_cache_tag_assoc (default 4 ways x 32 sets); PLRU checks follow L1_TAG_PLRU_EN.
module tb_l1_cache_tag_assoc;
  localparam int NW = 4;
  localparam int NS = 32;
  localparam int TW = 21;
`ifdef L1_TAG_PLRU_EN
  localparam bit PLRU = 1'b1;
`else
  localparam bit PLRU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   address_i = '0;
  logic          access_i = 1'b0;
  logic          ready_o, cache_hit_o, multi_hit_o;
  logic [NW-1:0] hit_oh_o;
  logic [1:0]    hit_way_o, lru_way_o;
  logic          update_i = 1'b0, invalidate_i = 1'b0;
  logic [1:0]    update_way_i = '0;
  logic [4:0]    update_set_i = '0;
  logic [TW-1:0] update_tag_i = '0;

  l1_cache_tag_assoc dut (
    .clk          (clk),
    .reset        (reset),
    .address_i    (address_i),
    .access_i     (access_i),
    .ready_o      (ready_o),
    .cache_hit_o  (cache_hit_o),
    .hit_oh_o     (hit_oh_o),
    .hit_way_o    (hit_way_o),
    .multi_hit_o  (multi_hit_o),
    .update_i     (update_i),
    .invalidate_i (invalidate_i),
    .update_way_i (update_way_i),
    .update_set_i (update_set_i),
    .update_tag_i (update_tag_i),
    .lru_way_o    (lru_way_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic [3:0] oh;
    logic [1:0] way;
    logic       multi;
    logic [1:0] lru;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] mk_addr(input logic [TW-1:0] t, input logic [4:0] s);
    return {t, s, 6'h00};
  endfunction

  task automatic push_exp(input string nm, input logic hit, input logic [3:0] oh,
                          input logic [1:0] way, input logic multi, input logic [1:0] lru);
    exp_t e;
    e = '{hit: hit, oh: oh, way: way, multi: multi, lru: lru};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    access_i     = 1'b0;
    update_i     = 1'b0;
    invalidate_i = 1'b0;
  endtask

  // Sets up a lookup for the current cycle without advancing the clock.
  task automatic issue(input string nm, input logic [TW-1:0] t, input logic [4:0] s,
                       input logic hit, input logic [3:0] oh, input logic [1:0] way,
                       input logic multi, input logic [1:0] lru);
    address_i = mk_addr(t, s);
    access_i  = 1'b1;
    push_exp(nm, hit, oh, way, multi, lru);
  endtask

  task automatic lookup(input string nm, input logic [TW-1:0] t, input logic [4:0] s,
                        input logic hit, input logic [3:0] oh, input logic [1:0] way,
                        input logic multi, input logic [1:0] lru);
    issue(nm, t, s, hit, oh, way, multi, lru);
    step();
  endtask

  task automatic set_wr(input logic upd, input logic inv, input logic [1:0] w,
                        input logic [4:0] s, input logic [TW-1:0] t);
    update_i     = upd;
    invalidate_i = inv;
    update_way_i = w;
    update_set_i = s;
    update_tag_i = t;
  endtask

  task automatic count_clear(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_o) break;
      n++;
    end
  endtask

  // Monitor: a lookup sampled at a rising edge is checked at the following falling edge.
  initial begin
    logic  p;
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      p = access_i;
      @(negedge clk);
      if (p) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got=hit%0d want=no_entry", cache_hit_o);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          chk({nm, "_hit"},   32'(cache_hit_o), 32'(e.hit));
          chk({nm, "_oh"},    32'(hit_oh_o),    32'(e.oh));
          chk({nm, "_way"},   32'(hit_way_o),   32'(e.way));
          chk({nm, "_multi"}, 32'(multi_hit_o), 32'(e.multi));
          chk({nm, "_lru"},   32'(lru_way_o),   32'(e.lru));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int n;
    #3;
    chk("rst_ready", 32'(ready_o),     0);
    chk("rst_hit",   32'(cache_hit_o), 0);
    chk("rst_oh",    32'(hit_oh_o),    0);
    chk("rst_way",   32'(hit_way_o),   0);
    chk("rst_multi", 32'(multi_hit_o), 0);
    chk("rst_lru",   32'(lru_way_o),   0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    count_clear(n);
    chk("clear_len", 32'(n), NS);
    @(posedge clk);
    #1;

    lookup("cold_miss", 21'h55, 5'd3, 0, 4'b0000, 0, 0, 0);

    set_wr(1, 0, 2'd2, 5'd5, 21'h1234); step();
    lookup("fill_hit",  21'h1234, 5'd5, 1, 4'b0100, 2, 0, 0);
    lookup("tag_miss",  21'h1235, 5'd5, 0, 4'b0000, 0, 0, 0);
    set_wr(0, 1, 2'd2, 5'd5, 21'h0);
    lookup("inv_fwd",   21'h1234, 5'd5, 0, 4'b0000, 0, 0, 0);
    lookup("inv_after", 21'h1234, 5'd5, 0, 4'b0000, 0, 0, 0);

    set_wr(1, 0, 2'd1, 5'd9, 21'hABC);
    lookup("fill_fwd",  21'hABC, 5'd9, 1, 4'b0010, 1, 0, PLRU ? 2'd2 : 2'd0);

    set_wr(1, 0, 2'd1, 5'd7, 21'h77); step();
    set_wr(1, 0, 2'd3, 5'd7, 21'h77); step();
    lookup("multi",     21'h77, 5'd7, 1, 4'b1010, 1, 1, 0);
    lookup("other_set", 21'h77, 5'd8, 0, 4'b0000, 0, 0, 0);

    set_wr(1, 1, 2'd0, 5'd12, 21'h99); step();
    lookup("upd_wins",  21'h99, 5'd12, 1, 4'b0001, 0, 0, PLRU ? 2'd2 : 2'd0);

    set_wr(1, 0, 2'd3, 5'd31, 21'h1FFFFF); step();
    lookup("max_tag",   21'h1FFFFF, 5'd31, 1, 4'b1000, 3, 0, 0);

    for (int w = 0; w < 4; w++) begin
      set_wr(1, 0, 2'(w), 5'd0, 21'h10 + 21'(w));
      step();
    end
    lookup("plru_fill", 21'h10, 5'd0, 1, 4'b0001, 0, 0, 0);
    lookup("plru_hit",  21'h13, 5'd0, 1, 4'b1000, 3, 0, PLRU ? 2'd2 : 2'd0);
    step();

    reset = 1'b0;
    #1;
    chk("async_rst_ready", 32'(ready_o),     0);
    chk("async_rst_hit",   32'(cache_hit_o), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    chk("midclear_ready", 32'(ready_o), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    fork
      count_clear(n);
      begin
        repeat (3) @(posedge clk);
        #1;
        set_wr(1, 0, 2'd0, 5'd1, 21'h10);
        issue("clear_lookup", 21'h10, 5'd1, 0, 4'b0000, 0, 0, 0);
        step();
      end
    join
    chk("clear_len_restart", 32'(n), NS);
    @(posedge clk);
    #1;
    lookup("cleared_set1",  21'h10,     5'd1,  0, 4'b0000, 0, 0, 0);
    lookup("cleared_set0",  21'h13,     5'd0,  0, 4'b0000, 0, 0, 0);
    lookup("cleared_set31", 21'h1FFFFF, 5'd31, 0, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
